// File: rtl/rat_int_pkg.sv
// rat_int_pkg: shared state type, sizing helpers and priority encoder for rat_int_ctrl
package rat_int_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;
  localparam int N_SRC_DEF = 4;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    prio_enc = '0;
    for (int k = 7; k >= 0; k--)
      if (v[k]) prio_enc = 3'(k);
  endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: two-flop synchronizer plus rising-edge pulse for one interrupt line
module irq_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic i_irq,
  output logic o_edge
);
  logic r_s1, r_s2, r_prev;
  always_ff @(posedge CLK)
    if (RESET) {r_s1, r_s2, r_prev} <= '0;
    else {r_s1, r_s2, r_prev} <= {i_irq, r_s1, r_s2};
  assign o_edge = r_s2 & ~r_prev;
endmodule

// File: rtl/rat_int_ctrl.sv
// rat_int_ctrl: edge-latched, masked, fixed-priority interrupt controller with
// request/acknowledge handshake and in-service tracking until RETIE
module rat_int_ctrl import rat_int_pkg::*; #(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = id_width(N_SRC)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic             MASK_WE,
  input  logic [N_SRC-1:0] MASK_DIN,
  input  logic             I_SET,
  input  logic             I_CLR,
  input  logic             INT_ACK,
  input  logic             INT_DONE,
  output logic             INT_R,
  output logic [ID_W-1:0]  INT_ID,
  output logic             IE,
  output logic [N_SRC-1:0] MASK,
  output logic [N_SRC-1:0] PENDING,
  output logic             IN_SVC
);
  state_t r_state, w_state_nx;
  logic [ID_W-1:0] r_id, w_id_nx;
  logic [N_SRC-1:0] r_pend, r_mask, w_edge, w_elig, w_clr;
  logic r_ie, w_ack;
  genvar i;
  generate
    for (i = 0; i < N_SRC; i++) begin : g_sync
      irq_sync_edge u_sync (.CLK(CLK), .RESET(RESET), .i_irq(IRQ[i]), .o_edge(w_edge[i]));
    end
  endgenerate
  assign w_elig = r_pend & r_mask;
  assign w_ack  = INT_ACK & (r_state == REQ);
  assign w_clr  = w_ack ? (N_SRC'(1) << r_id) : '0;
  always_comb begin
    w_state_nx = r_state;
    w_id_nx    = r_id;
    unique case (r_state)
      IDLE: if (r_ie && |w_elig) begin
        w_state_nx = REQ;
        w_id_nx    = ID_W'(prio_enc(8'(w_elig)));
      end
      REQ:  w_state_nx = INT_ACK ? SVC : (!r_ie || !r_mask[r_id]) ? IDLE : REQ;
      SVC:  w_state_nx = INT_DONE ? IDLE : SVC;
      default: w_state_nx = IDLE;
    endcase
  end
  // a new edge ORs in after the ACK clear so it survives as a fresh event
  always_ff @(posedge CLK)
    if (RESET) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_ie    <= 1'b0;
      r_mask  <= '1;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_id    <= w_id_nx;
      r_ie    <= !w_ack && !I_CLR && (I_SET || INT_DONE || r_ie);
      r_mask  <= MASK_WE ? MASK_DIN : r_mask;
      r_pend  <= (r_pend & ~w_clr) | w_edge;
    end
  assign INT_R   = (r_state == REQ);
  assign IN_SVC  = (r_state == SVC);
  assign INT_ID  = r_id;
  assign IE      = r_ie;
  assign MASK    = r_mask;
  assign PENDING = r_pend;
endmodule
